mult_unit: RTL and testbench

//   Iterative shift-add multiplier for MULT/MULTU, plus the HI/LO register pair that MFHI/MFLO read.

---
 rtl/mult_unit_if.sv | 30 +++
 rtl/mult_unit.sv | 119 +++++++++++
 tb/tb_mult_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_unit_if.sv
// Purpose: request/result bundle between the EX stage and the iterative multiplier.
//   master: issues start/abort/MTHI/MTLO and operands; observes ready/busy/done/hi/lo.
//   slave : the multiplier side of the same signals.
interface mult_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             abort;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b, abort, hi_we, lo_we, wdata,
        input  ready, busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b, abort, hi_we, lo_we, wdata,
        output ready, busy, done, hi, lo
    );
endinterface

// File: rtl/mult_unit.sv
// Purpose: iterative shift-add multiplier for MULT/MULTU plus the HI/LO register pair.
//   Retires one multiplier bit per cycle; a full multiply holds ready low for WIDTH+1 cycles.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high reset
//   bus    : mult_unit_if.slave (start/is_signed/op_a/op_b/abort/hi_we/lo_we/wdata in,
//            ready/busy/done/hi/lo out, all outputs registered)
module mult_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    mult_unit_if.slave  bus
);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_ma;
    logic [WIDTH-1:0] r_mb;
    logic             r_neg;
    logic [PW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_prod;
    logic             w_last;

    // Operand magnitudes; the most negative value negates to itself, which is its correct unsigned magnitude.
    assign w_mag_a  = (bus.is_signed && bus.op_a[WIDTH-1]) ? WIDTH'(-bus.op_a) : bus.op_a;
    assign w_mag_b  = (bus.is_signed && bus.op_b[WIDTH-1]) ? WIDTH'(-bus.op_b) : bus.op_b;

    // Partial product for the multiplier bit being retired this cycle.
    assign w_addend = r_mb[0] ? (PW'(r_ma) << r_cnt) : '0;
    assign w_prod   = r_neg ? PW'(-r_acc) : r_acc;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Control FSM, datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ma    <= '0;
            r_mb    <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.hi_we) r_hi <= bus.wdata;
                    if (bus.lo_we) r_lo <= bus.wdata;
                    // abort flushes the issuing instruction, so it overrides a same-cycle start
                    if (bus.start && !bus.abort) begin
                        r_ma    <= w_mag_a;
                        r_mb    <= w_mag_b;
                        r_neg   <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_acc + w_addend;
                        r_mb  <= r_mb >> 1;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (!bus.abort) begin
                        r_hi   <= w_prod[PW-1:WIDTH];
                        r_lo   <= w_prod[WIDTH-1:0];
                        r_done <= 1'b1;
                    end
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_unit_if #(.WIDTH(32)) bus ();

    mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-width product with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        bus.hi_we = h;
        bus.lo_we = l;
        bus.wdata = d;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
        check("mt_hi", 64'(bus.hi), 64'(m_hi));
        check("mt_lo", 64'(bus.lo), 64'(m_lo));
    endtask

    // One multiply with optional disturbances at given busy-cycle indices (-1 = none).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int restart_at, input int abort_at, input int reset_at,
                          input int mt_at, input logic mt_with_start, input logic [31:0] mt_data);
        logic [63:0] p;
        int          cycles;
        int          dn;
        bus.start     = 1'b1;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.is_signed = s;
        if (mt_with_start) begin
            bus.hi_we = 1'b1;
            bus.wdata = mt_data;
        end
        tick();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        if (mt_with_start) begin
            m_hi = mt_data;
            check("mt_with_start_hi", 64'(bus.hi), 64'(m_hi));
        end
        check("ready_drop", 64'(bus.ready), 64'(1'b0));
        check("busy_rise", 64'(bus.busy), 64'(1'b1));
        cycles = 0;
        dn     = 0;
        while (bus.ready !== 1'b1 && cycles < 100) begin
            if (cycles == restart_at) begin
                bus.start     = 1'b1;
                bus.is_signed = ~s;
            end
            if (cycles == abort_at) bus.abort = 1'b1;
            if (cycles == reset_at) reset = 1'b1;
            if (cycles == mt_at) begin
                bus.hi_we = 1'b1;
                bus.wdata = $urandom;
            end
            tick();
            bus.start = 1'b0;
            bus.abort = 1'b0;
            reset     = 1'b0;
            bus.hi_we = 1'b0;
            cycles++;
            if (bus.done === 1'b1) dn++;
            if (mt_at >= 0 && cycles == mt_at + 1)
                check("mt_busy_ignored", 64'(bus.hi), 64'(m_hi));
        end
        if (abort_at >= 0) begin
            check("abort_latency", 64'(cycles), 64'(abort_at + 1));
            check("abort_no_done", 64'(dn), 64'(0));
        end else if (reset_at >= 0) begin
            m_hi = '0;
            m_lo = '0;
            check("reset_latency", 64'(cycles), 64'(reset_at + 1));
            check("reset_no_done", 64'(dn), 64'(0));
        end else begin
            p    = ref_prod(a, b, s);
            m_hi = p[63:32];
            m_lo = p[31:0];
            check("latency", 64'(cycles), 64'(33));
            check("done_pulses", 64'(dn), 64'(1));
        end
        check("hi", 64'(bus.hi), 64'(m_hi));
        check("lo", 64'(bus.lo), 64'(m_lo));
        check("busy_fall", 64'(bus.busy), 64'(1'b0));
        tick();
        check("done_after", 64'(bus.done), 64'(1'b0));
        check("ready_after", 64'(bus.ready), 64'(1'b1));
    endtask

    task automatic mult(input logic [31:0] a, input logic [31:0] b, input logic s);
        run_op(a, b, s, -1, -1, -1, -1, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] pick_op();
        int sel;
        sel = int'($urandom_range(0, 5));
        case (sel)
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.abort     = 1'b0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.wdata     = '0;
        reset         = 1'b1;
        tick();
        tick();
        check("rst_ready", 64'(bus.ready), 64'(1'b1));
        check("rst_busy", 64'(bus.busy), 64'(1'b0));
        check("rst_done", 64'(bus.done), 64'(1'b0));
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        reset = 1'b0;
        tick();

        mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_hi", 64'(bus.hi), 64'(32'hFFFF_FFFE));
        check("multu_max_lo", 64'(bus.lo), 64'(32'h0000_0001));

        mult(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        mult(32'h8000_0000, 32'h8000_0000, 1'b1);
        check("mult_minneg_hi", 64'(bus.hi), 64'(32'h4000_0000));

        run_op(32'd7, 32'hFFFF_FFFD, 1'b1, 10, -1, -1, -1, 1'b0, 32'h0);
        check("mult_7x-3_lo", 64'(bus.lo), 64'(32'hFFFF_FFEB));

        mt_write(1'b1, 1'b0, 32'h12);
        mt_write(1'b0, 1'b1, 32'h34);
        run_op(32'd1234, 32'd5678, 1'b0, -1, 5, -1, -1, 1'b0, 32'h0);
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, -1, 32, -1, -1, 1'b0, 32'h0);

        mt_write(1'b1, 1'b0, 32'hA5A5_A5A5);
        mt_write(1'b0, 1'b1, 32'h5A5A_5A5A);
        run_op($urandom, $urandom, 1'b1, -1, -1, -1, 7, 1'b0, 32'h0);
        mt_write(1'b1, 1'b1, 32'h0F0F_0F0F);
        run_op(32'hFFFF_FFF0, 32'd3, 1'b1, -1, -1, -1, -1, 1'b1, 32'hCAFE_F00D);

        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, -1, -1, 16, -1, 1'b0, 32'h0);

        // start and abort together in IDLE: no operation begins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.op_a  = 32'd9;
        bus.op_b  = 32'd9;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_ready", 64'(bus.ready), 64'(1'b1));
        check("start_abort_busy", 64'(bus.busy), 64'(1'b0));
        tick();
        check("start_abort_ready2", 64'(bus.ready), 64'(1'b1));
        check("start_abort_hi", 64'(bus.hi), 64'(m_hi));
        check("start_abort_lo", 64'(bus.lo), 64'(m_lo));

        mult(32'h0, $urandom, 1'b0);
        for (int i = 0; i < 16; i++) begin
            mult(pick_op(), pick_op(), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
